// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants, types and helpers for the register-file write scheduler.
package regfile_pkg;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 10;
  localparam int unsigned NREGS = 8;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  // Decode a register address into a one-hot scoreboard mask.
  function automatic logic [NREGS-1:0] reg_onehot(input reg_addr_t a);
    logic [NREGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundle of requester, register-file write, reservation and hazard-query signals.
interface regfile_write_scheduler_if
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 2
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_ws;
  logic [NREQ*DW-1:0] req_wd;
  logic               rf_wf;
  reg_addr_t          rf_ws;
  reg_data_t          rf_wd;
  logic               rsv_valid;
  reg_addr_t          rsv_ws;
  logic               rsv_ready;
  reg_addr_t          chk_rs1;
  reg_addr_t          chk_rs2;
  logic               hazard;
  logic [NREGS-1:0]   pending;
  logic               err_unreserved;

  // Producers, issue logic and readers drive requests and queries.
  modport master (
    output req_valid, req_ws, req_wd, rsv_valid, rsv_ws, chk_rs1, chk_rs2,
    input  req_ready, rf_wf, rf_ws, rf_wd, rsv_ready, hazard, pending, err_unreserved
  );

  // The scheduler answers them and drives the register-file write port.
  modport slave (
    input  req_valid, req_ws, req_wd, rsv_valid, rsv_ws, chk_rs1, chk_rs2,
    output req_ready, rf_wf, rf_ws, rf_wd, rsv_ready, hazard, pending, err_unreserved
  );

endinterface

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at/after the pointer.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx,
  output logic                 o_any
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_cand;

  // Position p advanced by k, wrapping at N.
  function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // Scan requesters starting at the pointer; the first active one wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = rot(r_ptr, k);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt_idx     = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= rot(o_gnt_idx, 1);
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Round-robin sharing of the register-file write port plus a pending-write scoreboard.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input logic                        clk,
  input logic                        rst_n,
  regfile_write_scheduler_if.slave   bus
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [NREQ-1:0]  w_req;
  logic [NREQ-1:0]  w_gnt;
  logic [PW-1:0]    w_gnt_idx;
  logic             w_any;
  reg_addr_t        w_gnt_ws;
  reg_data_t        w_gnt_wd;
  logic             w_rsv_ready;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  logic             r_wf;
  reg_addr_t        r_ws;
  reg_data_t        r_wd;
  logic [NREGS-1:0] r_pending;
  logic             r_err;

  // No grants while reset is held so requesters cannot mistake a grant for a handshake.
  assign w_req = bus.req_valid & {NREQ{rst_n}};

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_gnt_ws = bus.req_ws[w_gnt_idx*AW +: AW];
  assign w_gnt_wd = bus.req_wd[w_gnt_idx*DW +: DW];

  // Reservations are refused while the register already has a write outstanding.
  assign w_rsv_ready = bus.rsv_valid & ~r_pending[bus.rsv_ws];

  // Scoreboard set/clear masks: clear follows the registered write, so the
  // pending bit stays visible through the rf_wf cycle.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_rsv_ready) w_set = reg_onehot(bus.rsv_ws);
    if (r_wf)        w_clr = reg_onehot(r_ws);
  end

  // Register the granted write for the register-file port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wf <= 1'b0;
      r_ws <= '0;
      r_wd <= '0;
    end else begin
      r_wf <= w_any;
      if (w_any) begin
        r_ws <= w_gnt_ws;
        r_wd <= w_gnt_wd;
      end
    end
  end

  // Scoreboard update and sticky unreserved-write flag, both judged in the rf_wf cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (r_wf && !r_pending[r_ws]) r_err <= 1'b1;
    end
  end

  assign bus.req_ready      = w_gnt;
  assign bus.rf_wf          = r_wf;
  assign bus.rf_ws          = r_ws;
  assign bus.rf_wd          = r_wd;
  assign bus.rsv_ready      = w_rsv_ready;
  assign bus.hazard         = r_pending[bus.chk_rs1] | r_pending[bus.chk_rs2];
  assign bus.pending        = r_pending;
  assign bus.err_unreserved = r_err;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with hand-computed expectations.
module tb_regfile_write_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  regfile_write_scheduler_if #(.NREQ(2)) bus();

  regfile_write_scheduler #(.NREQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.req_valid = 2'b11;
    bus.req_ws    = {3'd2, 3'd1};
    bus.req_wd    = {10'h222, 10'h111};
    bus.rsv_valid = 1'b0;
    bus.rsv_ws    = '0;
    bus.chk_rs1   = '0;
    bus.chk_rs2   = '0;

    // Reset held with both requesters valid
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("rst_wf", bus.rf_wf, 0);
      chk("rst_pend", bus.pending, 8'h00);
      chk("rst_ready", bus.req_ready, 2'b00);
      chk("rst_err", bus.err_unreserved, 0);
    end
    tick();
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    settle();
    chk("rel_wf", bus.rf_wf, 0);

    // Fairness: pre-reserve R1 and R2
    tick(); bus.rsv_valid = 1'b1; bus.rsv_ws = 3'd1; settle();
    chk("fr_rsv1", bus.rsv_ready, 1);
    tick(); bus.rsv_ws = 3'd2; settle();
    chk("fr_rsv2", bus.rsv_ready, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.req_valid = 2'b11;
      bus.req_ws    = {3'd2, 3'd1};
      bus.req_wd    = {10'h222, 10'h111};
      bus.rsv_valid = (k >= 2);
      bus.rsv_ws    = (k % 2 == 0) ? 3'd1 : 3'd2;
      settle();
      chk("fr_gnt", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k >= 1) begin
        chk("fr_wf", bus.rf_wf, 1);
        chk("fr_ws", bus.rf_ws, ((k - 1) % 2 == 0) ? 3'd1 : 3'd2);
      end
      if (k >= 2) chk("fr_rsv", bus.rsv_ready, 1);
    end
    tick(); bus.req_valid = 2'b00; bus.rsv_valid = 1'b0; settle();
    chk("fr_last_wf", bus.rf_wf, 1);
    chk("fr_last_ws", bus.rf_ws, 3'd2);
    chk("fr_last_wd", bus.rf_wd, 10'h222);
    tick(); settle();
    chk("fr_idle_wf", bus.rf_wf, 0);
    chk("fr_pend", bus.pending, 8'h00);
    chk("fr_err", bus.err_unreserved, 0);

    // Single write to R5
    tick(); bus.rsv_valid = 1'b1; bus.rsv_ws = 3'd5; settle();
    chk("sw_rsv", bus.rsv_ready, 1);
    tick();
    bus.rsv_valid = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_ws    = {3'd0, 3'd5};
    bus.req_wd    = {10'h000, 10'h2A3};
    bus.chk_rs1   = 3'd5;
    bus.chk_rs2   = 3'd0;
    settle();
    chk("sw_pend", bus.pending, 8'h20);
    chk("sw_ready", bus.req_ready, 2'b01);
    chk("sw_haz_t", bus.hazard, 1);
    chk("sw_wf_t", bus.rf_wf, 0);
    tick(); bus.req_valid = 2'b00; settle();
    chk("sw_wf", bus.rf_wf, 1);
    chk("sw_ws", bus.rf_ws, 3'd5);
    chk("sw_wd", bus.rf_wd, 10'h2A3);
    chk("sw_haz_t1", bus.hazard, 1);
    chk("sw_ready0", bus.req_ready, 2'b00);
    tick(); settle();
    chk("sw_wf_t2", bus.rf_wf, 0);
    chk("sw_pend_t2", bus.pending, 8'h00);
    chk("sw_haz_t2", bus.hazard, 0);

    // WAW block on R3
    tick(); bus.rsv_valid = 1'b1; bus.rsv_ws = 3'd3; settle();
    chk("waw_rsv", bus.rsv_ready, 1);
    tick(); settle();
    chk("waw_blk0", bus.rsv_ready, 0);
    chk("waw_pend", bus.pending, 8'h08);
    tick();
    bus.req_valid = 2'b01;
    bus.req_ws    = {3'd0, 3'd3};
    bus.req_wd    = {10'h000, 10'h03C};
    settle();
    chk("waw_gnt", bus.req_ready, 2'b01);
    chk("waw_blk1", bus.rsv_ready, 0);
    tick(); bus.req_valid = 2'b00; settle();
    chk("waw_wf", bus.rf_wf, 1);
    chk("waw_ws", bus.rf_ws, 3'd3);
    chk("waw_blk2", bus.rsv_ready, 0);
    tick(); settle();
    chk("waw_free", bus.rsv_ready, 1);
    tick(); bus.rsv_valid = 1'b0; settle();
    chk("waw_repend", bus.pending, 8'h08);

    // Unreserved write by requester 1 to R7
    tick();
    bus.req_valid = 2'b10;
    bus.req_ws    = {3'd7, 3'd0};
    bus.req_wd    = {10'h155, 10'h000};
    settle();
    chk("ur_gnt", bus.req_ready, 2'b10);
    chk("ur_err0", bus.err_unreserved, 0);
    tick(); bus.req_valid = 2'b00; settle();
    chk("ur_wf", bus.rf_wf, 1);
    chk("ur_ws", bus.rf_ws, 3'd7);
    chk("ur_wd", bus.rf_wd, 10'h155);
    chk("ur_err1", bus.err_unreserved, 0);
    tick(); settle();
    chk("ur_err_set", bus.err_unreserved, 1);
    tick(); settle();
    chk("ur_err_hold", bus.err_unreserved, 1);
    chk("ur_wf_idle", bus.rf_wf, 0);
    chk("ur_pend", bus.pending, 8'h08);

    // Reset between grant and the rf_wf cycle
    tick();
    bus.req_valid = 2'b01;
    bus.req_ws    = {3'd0, 3'd3};
    bus.req_wd    = {10'h000, 10'h0AA};
    settle();
    chk("mr_gnt", bus.req_ready, 2'b01);
    #1;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    chk("mr_pend", bus.pending, 8'h00);
    chk("mr_err", bus.err_unreserved, 0);
    chk("mr_wf0", bus.rf_wf, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      chk("mr_wf", bus.rf_wf, 0);
      chk("mr_pend_h", bus.pending, 8'h00);
    end
    tick(); rst_n = 1'b1; settle();
    chk("mr_rel_wf", bus.rf_wf, 0);
    tick(); settle();
    chk("mr_post_wf", bus.rf_wf, 0);
    chk("mr_post_pend", bus.pending, 8'h00);
    chk("mr_post_err", bus.err_unreserved, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
